seg7_pair_decoder: RTL and testbench

Sequential decoder for the two-digit, active-low seven-segment bus that the lab's 6-bit display driver produces. It recovers the 6-bit value from a 14-bit segment word and requires the word to be stable for a configurable number of cycles before committing it. Each commit produces a one-cycle `valid` pulse, or an `err` pulse if the pattern is not legal. It is used as a loopback monitor and self-check block on the display path and in benches for the lab counter designs.

---
 rtl/seg7_pair_decoder_if.sv | 23 ++
 rtl/seg7_pair_decoder.sv | 133 +++++++++++++
 tb/tb_seg7_pair_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pair_decoder_if.sv
// Bundle for the seven-segment loopback monitor: segment word in, decoded value and status flags out.
// Latency: none (wires only).
// Backpressure: none; the segment word is sampled every cycle.
interface seg7_pair_decoder_if;
  logic [13:0] dispIn;
  logic [5:0]  numOut;
  logic        valid;
  logic        err;
  logic        locked;
  logic [7:0]  errCount;

  // Display-side driver: presents the segment word, observes the decode results
  modport master (
    output dispIn,
    input  numOut, valid, err, locked, errCount
  );

  // Decoder side
  modport slave (
    input  dispIn,
    output numOut, valid, err, locked, errCount
  );
endinterface

// File: rtl/seg7_pair_decoder.sv
// Decodes a two-digit active-low 7-seg word to 6 bits once it holds for STABLE_CYCLES edges; SEG7_ERR_COUNT_EN builds the err counter.
// Latency: commit registered STABLE_CYCLES-1 edges after the first sampling edge; valid/err pulse the cycle after.
// Backpressure: none; dispIn is sampled every edge and pulses are single-cycle, never stalled.
module seg7_pair_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  seg7_pair_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [13:0]   BLANK   = 14'h3FFF;

  typedef enum logic {SETTLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [13:0]   samp_q, samp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    num_q, num_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          commit;
  logic [4:0]    lo_dec, hi_dec;
  logic          legal;

  // Active-low segment pattern -> {legal, digit value}
  function automatic logic [4:0] dec_digit(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0010000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // State and pulse registers; everything clears straight away on rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SETTLE;
      samp_q  <= BLANK;
      cnt_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next state: any change restarts the window (and wins over a commit);
  // a commit fires on the edge the count reaches STABLE_CYCLES, which with
  // STABLE_CYCLES=1 is the very edge a new pattern is first sampled
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (bus.dispIn != samp_q) begin
      samp_d  = bus.dispIn;
      cnt_d   = CW'(1);
      state_d = SETTLE;
    end else if (state_q == SETTLE && cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (state_d == SETTLE && cnt_d == CNT_MAX) begin
      commit  = 1'b1;
      state_d = LOCKED;
    end
  end

  // Outputs: decode the pattern being committed; illegal patterns keep numOut
  always_comb begin
    lo_dec  = dec_digit(samp_d[6:0]);
    hi_dec  = dec_digit(samp_d[13:7]);
    legal   = lo_dec[4] & hi_dec[4] & (hi_dec[3:2] == 2'b00);
    valid_d = commit & legal;
    err_d   = commit & ~legal;
    num_d   = valid_d ? {hi_dec[1:0], lo_dec[3:0]} : num_q;
  end

`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // Saturating count of err pulses
  always_comb begin
    errcnt_d = errcnt_q;
    if (err_d && errcnt_q != 8'hFF) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  // Error counter register, cleared only by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign bus.errCount = errcnt_q;
`else
  assign bus.errCount = 8'd0;
`endif

  assign bus.numOut = num_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.locked = (state_q == LOCKED);

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Scoreboard bench: two decoders (STABLE_CYCLES=4 and 1) watch the same segment bus.
// Stimulus pushes the per-edge expectation from a run-length reference model; a negedge monitor pops and compares.
// No backpressure exists; every edge produces exactly one expectation record per decoder.
module tb_seg7_pair_decoder;

  typedef struct {
    int         ecyc;
    bit         vld;
    bit         er;
    bit         lk;
    logic [5:0] num;
    int         ec;
  } rec_t;

  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [13:0] BLANK = 14'h3FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] disp = BLANK;
  int          edge_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  seg7_pair_decoder_if if4 ();
  seg7_pair_decoder_if if1 ();
  assign if4.dispIn = disp;
  assign if1.dispIn = disp;

  seg7_pair_decoder #(.STABLE_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  seg7_pair_decoder #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model state: current pattern, how many edges it has been seen,
  // whether this run was already committed
  int          m_s   [2] = '{4, 1};
  logic [13:0] m_cur [2];
  int          m_run [2];
  bit          m_com [2];
  logic [5:0]  m_num [2];
  int          m_ec  [2];
  rec_t        q4[$];
  rec_t        q1[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  function automatic int dig(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (PAT[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [13:0] enc(input int v);
    return {PAT[(v >> 4) & 3], PAT[v & 15]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = BLANK; m_run[d] = 0; m_com[d] = 0; m_num[d] = 0; m_ec[d] = 0;
    end
  endtask

  task automatic model_edge(input int d, input logic [13:0] p, input int e, output rec_t r);
    int lo, hi;
    r.ecyc = e; r.vld = 0; r.er = 0;
    if (p != m_cur[d]) begin
      m_cur[d] = p; m_run[d] = 1; m_com[d] = 0;
    end else begin
      m_run[d]++;
    end
    if (!m_com[d] && m_run[d] >= m_s[d]) begin
      m_com[d] = 1;
      lo = dig(p[6:0]);
      hi = dig(p[13:7]);
      if (lo >= 0 && hi >= 0 && hi < 4) begin
        r.vld = 1;
        m_num[d] = 6'(hi * 16 + lo);
      end else begin
        r.er = 1;
`ifdef SEG7_ERR_COUNT_EN
        if (m_ec[d] < 255) m_ec[d]++;
`endif
      end
    end
    r.lk = m_com[d]; r.num = m_num[d]; r.ec = m_ec[d];
  endtask

  task automatic step(input logic [13:0] p);
    rec_t r;
    disp = p;
    model_edge(0, p, edge_cnt + 1, r); q4.push_back(r);
    model_edge(1, p, edge_cnt + 1, r); q1.push_back(r);
    @(posedge clk); #1;
  endtask

  task automatic hold(input logic [13:0] p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q4.delete(); q1.delete();
    model_reset();
    #1;
    chk("rst4_num", int'(if4.numOut), 0);   chk("rst1_num", int'(if1.numOut), 0);
    chk("rst4_valid", int'(if4.valid), 0);  chk("rst1_valid", int'(if1.valid), 0);
    chk("rst4_err", int'(if4.err), 0);      chk("rst1_err", int'(if1.err), 0);
    chk("rst4_locked", int'(if4.locked), 0); chk("rst1_locked", int'(if1.locked), 0);
    chk("rst4_errcnt", int'(if4.errCount), 0); chk("rst1_errcnt", int'(if1.errCount), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic mon_one(input string tag, input bit have, input rec_t r,
                         input logic v, input logic e, input logic l,
                         input logic [5:0] n, input logic [7:0] ec);
    if (have) begin
      chk({tag, "_valid"}, int'(v), int'(r.vld));
      chk({tag, "_err"}, int'(e), int'(r.er));
      chk({tag, "_locked"}, int'(l), int'(r.lk));
      chk({tag, "_numOut"}, int'(n), int'(r.num));
      chk({tag, "_errCount"}, int'(ec), r.ec);
    end else begin
      chk({tag, "_unexpected_pulse"}, int'(v | e), 0);
    end
  endtask

  rec_t r4, r1;
  bit   h4, h1;

  // Monitor: away from the active edge, match each DUT's outputs to its queued expectation
  always @(negedge clk) begin
    h4 = (q4.size() > 0) && (q4[0].ecyc == edge_cnt);
    if (h4) r4 = q4.pop_front();
    h1 = (q1.size() > 0) && (q1[0].ecyc == edge_cnt);
    if (h1) r1 = q1.pop_front();
    mon_one("s4", h4, r4, if4.valid, if4.err, if4.locked, if4.numOut, if4.errCount);
    mon_one("s1", h1, r1, if1.valid, if1.err, if1.locked, if1.numOut, if1.errCount);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, nv, len;
    logic [13:0] p;
    do_reset();
    // blank held from reset commits as err
    hold(BLANK, 5);
    // basic decode: 33
    hold(14'b0100100_1111001, 6);
    // maximum value then zero
    hold(14'b0110000_0001110, 6);
    hold(14'b1000000_1000000, 6);
    // glitch on a locked 33
    hold(14'b0100100_1111001, 6);
    hold(14'b1000000_1111001, 2);
    hold(14'b0100100_1111001, 6);
    // illegal high digit 4
    hold(14'b0011001_1000000, 6);
    // reset two edges into a settle window, then the same pattern
    hold(14'b0100100_1111001, 2);
    do_reset();
    hold(14'b0100100_1111001, 6);
    // change landing exactly on the would-be commit edge
    hold(enc(17), 3);
    hold(enc(42), 5);
    // randomized windows of legal and arbitrary patterns
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) p = 14'($urandom);
      else p = enc($urandom_range(0, 63));
      hold(p, len);
    end
    // a new pattern every edge
    v = 5;
    for (int i = 0; i < 20; i++) begin
      nv = (v + 1 + $urandom_range(0, 61)) % 64;
      v = nv;
      step(enc(v));
    end
    // error counter saturation: alternating illegal / blank windows
    for (int i = 0; i < 300; i++) begin
      hold((i % 2 == 0) ? 14'b0011001_1000000 : BLANK, 4);
    end
    hold(enc(9), 5);
    repeat (2) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
